// File: rtl/xnor_corr_pkg.sv
// Shared types and helpers for the XNOR pattern correlator.
// Holds the FSM state encoding, the score-width derivation and a popcount.
// No logic of its own.
package xnor_corr_pkg;

  // Widest window the popcount helper can accept (zero-extended input).
  localparam int POP_MAX_W = 256;

  // FILL: collecting the first N bits after reset/LOAD; RUN: window is valid.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Score must represent 0..N inclusive.
  function automatic int score_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Number of set bits in a zero-extended vector.
  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/xnor_vec.sv
// Bitwise XNOR bank: eq[i] is 1 where a[i] and b[i] agree.
// Latency: purely combinational.
// Backpressure: none, no flow control.
module xnor_vec #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_eq
);

  assign o_eq = ~(i_a ^ i_b);

endmodule

// File: rtl/xnor_correlator.sv
// Bit-serial correlator: shifts DIN into an N-bit window, scores it against a pattern.
// Latency: SCORE/MATCH/HITS update one edge after the bit that completes a window.
// Backpressure: none; DVALID gaps simply freeze the window, LOAD restarts the fill.
module xnor_correlator
  import xnor_corr_pkg::*;
#(
  parameter int  N  = 8,
  parameter int  CW = 8,
  localparam int SW = score_width(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [N-1:0]  i_pat,
  input  logic          i_din,
  input  logic          i_dvalid,
  input  logic [SW-1:0] i_thresh,
  output logic [SW-1:0] o_score,
  output logic          o_match,
  output logic          o_ready,
  output logic [CW-1:0] o_hits
);

  logic [N-1:0]  r_win;
  logic [N-1:0]  r_pat;
  logic [SW-1:0] r_fill_cnt;
  state_e        r_state;
  logic          r_score_pend;
  logic [SW-1:0] r_score;
  logic          r_match;
  logic [CW-1:0] r_hits;

  logic [N-1:0]  w_eq;
  logic [SW-1:0] w_pop;
  logic          w_hit;

  xnor_vec #(.N(N)) u_xnor_vec (
    .i_a  (r_win),
    .i_b  (r_pat),
    .o_eq (w_eq)
  );

  // Agreement count of the current window; threshold compared at the scoring edge.
  assign w_pop = SW'(popcount(POP_MAX_W'(w_eq)));
  assign w_hit = (w_pop >= i_thresh);

  // Window shift, fill counting, FILL->RUN transition and the score-pending flag.
  // LOAD wins over a same-cycle DVALID, so that bit never enters the window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat        <= '0;
      r_win        <= '0;
      r_fill_cnt   <= '0;
      r_state      <= ST_FILL;
      r_score_pend <= 1'b0;
    end else if (i_load) begin
      r_pat        <= i_pat;
      r_win        <= '0;
      r_fill_cnt   <= '0;
      r_state      <= ST_FILL;
      r_score_pend <= 1'b0;
    end else begin
      r_score_pend <= 1'b0;
      if (i_dvalid) begin
        r_win <= {r_win[N-2:0], i_din};
        if (r_state == ST_RUN) begin
          r_score_pend <= 1'b1;
        end else if (r_fill_cnt == SW'(N - 1)) begin
          // This bit completes the first window: score it too.
          r_state      <= ST_RUN;
          r_fill_cnt   <= '0;
          r_score_pend <= 1'b1;
        end else begin
          r_fill_cnt <= r_fill_cnt + SW'(1);
        end
      end
    end
  end

  // Score/match registers and saturating hit counter, updated one edge after a scored bit.
  // LOAD clears them and also drops any score pending from the previous edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_score <= '0;
      r_match <= 1'b0;
      r_hits  <= '0;
    end else if (i_load) begin
      r_score <= '0;
      r_match <= 1'b0;
      r_hits  <= '0;
    end else if (r_score_pend) begin
      r_score <= w_pop;
      r_match <= w_hit;
      if (w_hit && (r_hits != {CW{1'b1}})) begin
        r_hits <= r_hits + CW'(1);
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  assign o_score = r_score;
  assign o_match = r_match;
  assign o_ready = (r_state == ST_RUN);
  assign o_hits  = r_hits;

endmodule

// File: tb/tb_xnor_correlator.sv
// Directed bench for xnor_correlator (N=8) with a second CW=2 instance for saturation.
// All inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived from the pattern and bit streams below.
module tb_xnor_correlator;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] pat;
  logic       din;
  logic       dvalid;
  logic [3:0] thresh;

  logic [3:0] score;
  logic       match;
  logic       ready;
  logic [7:0] hits;

  logic [3:0] score2;
  logic       match2;
  logic       ready2;
  logic [1:0] hits2;

  int n_vec = 0;
  int n_mis = 0;

  xnor_correlator #(.N(8), .CW(8)) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_load   (load),
    .i_pat    (pat),
    .i_din    (din),
    .i_dvalid (dvalid),
    .i_thresh (thresh),
    .o_score  (score),
    .o_match  (match),
    .o_ready  (ready),
    .o_hits   (hits)
  );

  xnor_correlator #(.N(8), .CW(2)) u_dut_cw2 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_load   (load),
    .i_pat    (pat),
    .i_din    (din),
    .i_dvalid (dvalid),
    .i_thresh (thresh),
    .o_score  (score2),
    .o_match  (match2),
    .o_ready  (ready2),
    .o_hits   (hits2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    load   = 1'b0;
    dvalid = 1'b1;
    din    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
    end
  endtask

  task automatic idle();
    load   = 1'b0;
    dvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p);
    load   = 1'b1;
    pat    = p;
    dvalid = 1'b0;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    pat    = 8'h00;
    din    = 1'b0;
    dvalid = 1'b0;
    thresh = 4'd8;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_hits",  32'(hits),  32'd0);
    rst_n = 1'b1;

    // Exact match: B5 sent MSB first.
    thresh = 4'd8;
    do_load(8'hB5);
    send_byte(8'hB5 >> 1);  // warm-up stream, discarded by the LOAD that follows
    do_load(8'hB5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("exact_ready_bit7", 32'(ready), 32'd0);
    send_bit(1'b1);
    chk("exact_ready_bit8", 32'(ready), 32'd1);
    chk("exact_match_bit8", 32'(match), 32'd0);
    idle();
    chk("exact_score", 32'(score), 32'd8);
    chk("exact_match", 32'(match), 32'd1);
    chk("exact_hits",  32'(hits),  32'd1);
    idle();
    chk("exact_match_drop", 32'(match), 32'd0);
    chk("exact_score_hold", 32'(score), 32'd8);
    chk("exact_hits_hold",  32'(hits),  32'd1);

    // One-bit error, THRESH=8: no match.
    do_load(8'hB5);
    chk("load_clr_hits",  32'(hits),  32'd0);
    chk("load_clr_score", 32'(score), 32'd0);
    send_byte(8'hB4);
    idle();
    chk("err1_score", 32'(score), 32'd7);
    chk("err1_match", 32'(match), 32'd0);
    chk("err1_hits",  32'(hits),  32'd0);

    // One-bit error, THRESH=7, with DVALID gaps between bits.
    thresh = 4'd7;
    do_load(8'hB5);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'hB4;
      send_bit(v[i]);
      idle();
    end
    chk("err1t7_score", 32'(score), 32'd7);
    chk("err1t7_match", 32'(match), 32'd1);
    chk("err1t7_hits",  32'(hits),  32'd1);
    idle();
    chk("err1t7_gap_nomatch", 32'(match), 32'd0);

    // Sliding window: B5 B5 back to back; only windows after bit 8 and 16 match.
    thresh = 4'd8;
    do_load(8'hB5);
    for (int j = 1; j <= 16; j++) begin
      logic [15:0] s;
      s = 16'hB5B5;
      send_bit(s[16 - j]);
      chk($sformatf("slide_match_%0d", j), 32'(match), (j == 9) ? 32'd1 : 32'd0);
      if (j == 9) chk("slide_score_9", 32'(score), 32'd8);
    end
    idle();
    chk("slide_match_16", 32'(match), 32'd1);
    chk("slide_hits",     32'(hits),  32'd2);

    // THRESH=0: every scored window matches, none before READY. Zeros vs B5 agree in 3 bits.
    thresh = 4'd0;
    do_load(8'hB5);
    for (int j = 1; j <= 10; j++) begin
      send_bit(1'b0);
      chk($sformatf("t0_ready_%0d", j), 32'(ready), (j >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("t0_match_%0d", j), 32'(match), (j >= 9) ? 32'd1 : 32'd0);
    end
    idle();
    chk("t0_match_last", 32'(match), 32'd1);
    chk("t0_score",      32'(score), 32'd3);
    chk("t0_hits",       32'(hits),  32'd3);
    chk("t0_hits_cw2",   32'(hits2), 32'd3);

    // THRESH=9 never matches, even on an exact window.
    thresh = 4'd9;
    do_load(8'hB5);
    send_byte(8'hB5);
    idle();
    chk("t9_score", 32'(score), 32'd8);
    chk("t9_match", 32'(match), 32'd0);
    chk("t9_hits",  32'(hits),  32'd0);

    // Saturation: 5 matches leave CW=2 counter at 3, CW=8 counter at 5.
    thresh = 4'd0;
    do_load(8'hB5);
    for (int j = 1; j <= 12; j++) begin
      send_bit(1'b0);
    end
    idle();
    chk("sat_hits_cw8", 32'(hits),  32'd5);
    chk("sat_hits_cw2", 32'(hits2), 32'd3);

    // LOAD collides with DVALID right after the window completes.
    thresh = 4'd8;
    do_load(8'hB5);
    send_byte(8'hB5);
    chk("coll_ready_pre", 32'(ready), 32'd1);
    load   = 1'b1;
    pat    = 8'hB5;
    dvalid = 1'b1;
    din    = 1'b1;
    @(posedge clk);
    #1;
    load   = 1'b0;
    dvalid = 1'b0;
    chk("coll_ready", 32'(ready), 32'd0);
    chk("coll_hits",  32'(hits),  32'd0);
    chk("coll_score", 32'(score), 32'd0);
    chk("coll_match", 32'(match), 32'd0);
    idle();
    chk("coll_score_next", 32'(score), 32'd0);
    chk("coll_match_next", 32'(match), 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("coll_ready_bit7", 32'(ready), 32'd0);
    send_bit(1'b1);
    chk("coll_ready_bit8", 32'(ready), 32'd1);
    idle();
    chk("coll_score_fresh", 32'(score), 32'd8);
    chk("coll_match_fresh", 32'(match), 32'd1);
    chk("coll_hits_fresh",  32'(hits),  32'd1);

    // Async reset while in RUN, between clock edges.
    thresh = 4'd0;
    do_load(8'hB5);
    for (int j = 1; j <= 8; j++) send_bit(1'b0);
    idle();
    chk("ar_pre_match", 32'(match), 32'd1);
    chk("ar_pre_ready", 32'(ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_score", 32'(score), 32'd0);
    chk("ar_match", 32'(match), 32'd0);
    chk("ar_ready", 32'(ready), 32'd0);
    chk("ar_hits",  32'(hits),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Pattern register is back at 0, so eight ones agree in no position.
    for (int j = 1; j <= 7; j++) begin
      send_bit(1'b1);
      chk($sformatf("ar_post_match_%0d", j), 32'(match), 32'd0);
    end
    chk("ar_post_ready_7", 32'(ready), 32'd0);
    send_bit(1'b1);
    chk("ar_post_ready_8", 32'(ready), 32'd1);
    chk("ar_post_match_8", 32'(match), 32'd0);
    idle();
    chk("ar_post_match", 32'(match), 32'd1);
    chk("ar_post_score", 32'(score), 32'd0);
    chk("ar_post_hits",  32'(hits),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
